// File: rtl/inv_shift_rows_stage.sv
// AES-128 InvShiftRows as a one-deep registered pipeline stage with valid/ready handshake.
// Optional macro INV_SHIFT_ROWS_FWD_SEL_EN adds fwd_sel to select forward ShiftRows per state.
module inv_shift_rows_stage (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] invByteSData,
`ifdef INV_SHIFT_ROWS_FWD_SEL_EN
    input  logic         fwd_sel,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] invShiftRowData
);

    logic         valid_r;
    logic [127:0] data_r;
    logic [127:0] perm_s;
    logic         accept_s;

    // Byte k occupies bits [127-8k -: 8]; state is column-major (row = k%4, col = k/4).
    function automatic logic [7:0] byte_at(input logic [127:0] s, input int k);
        byte_at = s[127 - 8 * k -: 8];
    endfunction

    // Rows 1/2/3 rotated right by 1/2/3 columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        inv_shift_rows = {byte_at(s, 0),  byte_at(s, 13), byte_at(s, 10), byte_at(s, 7),
                          byte_at(s, 4),  byte_at(s, 1),  byte_at(s, 14), byte_at(s, 11),
                          byte_at(s, 8),  byte_at(s, 5),  byte_at(s, 2),  byte_at(s, 15),
                          byte_at(s, 12), byte_at(s, 9),  byte_at(s, 6),  byte_at(s, 3)};
    endfunction

`ifdef INV_SHIFT_ROWS_FWD_SEL_EN
    // Rows 1/2/3 rotated left by 1/2/3 columns (encrypt direction).
    function automatic logic [127:0] fwd_shift_rows(input logic [127:0] s);
        fwd_shift_rows = {byte_at(s, 0),  byte_at(s, 5),  byte_at(s, 10), byte_at(s, 15),
                          byte_at(s, 4),  byte_at(s, 9),  byte_at(s, 14), byte_at(s, 3),
                          byte_at(s, 8),  byte_at(s, 13), byte_at(s, 2),  byte_at(s, 7),
                          byte_at(s, 12), byte_at(s, 1),  byte_at(s, 6),  byte_at(s, 11)};
    endfunction
`endif

    assign in_ready = ~valid_r | out_ready;
    assign accept_s = in_valid & in_ready;

    // Select the permutation applied to the incoming state.
    always_comb begin
        perm_s = inv_shift_rows(invByteSData);
`ifdef INV_SHIFT_ROWS_FWD_SEL_EN
        if (fwd_sel) begin
            perm_s = fwd_shift_rows(invByteSData);
        end else begin
            perm_s = inv_shift_rows(invByteSData);
        end
`endif
    end

    // Output register: load on accept, hold under backpressure, clear valid on drain.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            valid_r <= 1'b0;
            data_r  <= 128'h0;
        end else if (accept_s) begin
            valid_r <= 1'b1;
            data_r  <= perm_s;
        end else if (out_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign out_valid       = valid_r;
    assign invShiftRowData = data_r;

endmodule

// File: tb/tb_inv_shift_rows_stage.sv
// Self-checking bench for inv_shift_rows_stage: directed vectors plus randomized handshake
// traffic scored against a row/column rotation model.
module tb_inv_shift_rows_stage;

    logic         clk;
    logic         n_rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] invByteSData;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] invShiftRowData;
`ifdef INV_SHIFT_ROWS_FWD_SEL_EN
    logic         fwd_sel;
`endif

    int checks = 0;
    int errors = 0;

    logic [127:0] exp_q[$];
    logic [127:0] exp_data;
    logic         s_valid;
    logic         s_ready;
    logic [127:0] s_data;

    inv_shift_rows_stage dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .invByteSData   (invByteSData),
`ifdef INV_SHIFT_ROWS_FWD_SEL_EN
        .fwd_sel        (fwd_sel),
`endif
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .invShiftRowData(invShiftRowData)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: build a 4x4 byte matrix and rotate each row by its index.
    function automatic logic [127:0] ref_model(input logic [127:0] s, input bit fwd);
        logic [7:0] m [4][4];
        logic [127:0] o;
        int src;
        for (int k = 0; k < 16; k++) m[k % 4][k / 4] = s[127 - 8 * k -: 8];
        o = 128'h0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                src = fwd ? (c + r) % 4 : (c - r + 4) % 4;
                o[127 - 8 * (4 * c + r) -: 8] = m[r][src];
            end
        end
        return o;
    endfunction

    // One clock cycle: drive at negedge, sample and score, then let the edge happen.
    task automatic cycle(input logic v, input logic [127:0] d, input logic rdy, input bit fwd = 1'b0);
        logic exp_valid;
        logic exp_ready;
        @(negedge clk);
        in_valid     = v;
        invByteSData = d;
        out_ready    = rdy;
`ifdef INV_SHIFT_ROWS_FWD_SEL_EN
        fwd_sel      = fwd;
`endif
        #1;
        s_valid = out_valid;
        s_ready = in_ready;
        s_data  = invShiftRowData;
        exp_valid = (exp_q.size() != 0);
        exp_ready = !exp_valid || rdy;
        checks++;
        if (s_valid !== exp_valid) begin
            errors++;
            $display("FAIL out_valid: got %b expected %b at %0t", s_valid, exp_valid, $time);
        end
        checks++;
        if (s_ready !== exp_ready) begin
            errors++;
            $display("FAIL in_ready: got %b expected %b at %0t", s_ready, exp_ready, $time);
        end
        checks++;
        if (s_data !== exp_data) begin
            errors++;
            $display("FAIL data: got %h expected %h at %0t", s_data, exp_data, $time);
        end
        if (exp_valid && rdy) void'(exp_q.pop_front());
        if (v && exp_ready) begin
            exp_data = ref_model(d, fwd);
            exp_q.push_back(exp_data);
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        invByteSData = 128'h0;
`ifdef INV_SHIFT_ROWS_FWD_SEL_EN
        fwd_sel = 1'b0;
`endif
        exp_q.delete();
        exp_data = 128'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || invShiftRowData !== 128'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: got v=%b d=%h r=%b expected v=0 d=0 r=1", out_valid, invShiftRowData, in_ready);
        end
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic test_vector1();
        cycle(1'b1, 128'hDB5C77AA2BD6040C51AC0A3DF41C4507, 1'b1);
        cycle(1'b0, 128'h0, 1'b1);
        checks++;
        if (s_valid !== 1'b1 || s_data !== 128'hDB1C0A0C2B5C453D51D67707F4AC04AA) begin
            errors++;
            $display("FAIL vector1: got v=%b d=%h expected v=1 d=DB1C0A0C2B5C453D51D67707F4AC04AA", s_valid, s_data);
        end
        cycle(1'b0, 128'h0, 1'b1);
    endtask

    task automatic test_back_to_back();
        cycle(1'b1, 128'hF76B38416DF88A09B0E52267E8C6BB6E, 1'b1);
        cycle(1'b1, 128'h27070E85C25599C2EB74D141EF518AB2, 1'b1);
        checks++;
        if (s_valid !== 1'b1 || s_data !== 128'hF7C622096D6BBB67B0F8386EE8E58A41) begin
            errors++;
            $display("FAIL b2b_first: got v=%b d=%h expected v=1 d=F7C622096D6BBB67B0F8386EE8E58A41", s_valid, s_data);
        end
        cycle(1'b0, 128'h0, 1'b1);
        checks++;
        if (s_valid !== 1'b1 || s_data !== 128'h2751D1C2C2078A41EB550EB2EF749985) begin
            errors++;
            $display("FAIL b2b_second: got v=%b d=%h expected v=1 d=2751D1C2C2078A41EB550EB2EF749985", s_valid, s_data);
        end
        cycle(1'b0, 128'h0, 1'b1);
    endtask

    task automatic test_backpressure();
        logic [127:0] a;
        logic [127:0] b;
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        cycle(1'b1, a, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, b, 1'b0);
            checks++;
            if (s_ready !== 1'b0 || s_valid !== 1'b1 || s_data !== ref_model(a, 1'b0)) begin
                errors++;
                $display("FAIL backpressure_hold: got r=%b v=%b d=%h expected r=0 v=1 d=%h", s_ready, s_valid, s_data, ref_model(a, 1'b0));
            end
        end
        cycle(1'b1, b, 1'b1);
        cycle(1'b0, 128'h0, 1'b1);
        checks++;
        if (s_valid !== 1'b1 || s_data !== ref_model(b, 1'b0)) begin
            errors++;
            $display("FAIL backpressure_release: got v=%b d=%h expected v=1 d=%h", s_valid, s_data, ref_model(b, 1'b0));
        end
        cycle(1'b0, 128'h0, 1'b0);
        cycle(1'b0, 128'h0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), {$urandom, $urandom, $urandom, $urandom},
                  1'($urandom_range(0, 2) != 0));
        end
        cycle(1'b0, 128'h0, 1'b1);
        cycle(1'b0, 128'h0, 1'b1);
    endtask

    task automatic test_async_reset();
        cycle(1'b1, 128'h00112233445566778899AABBCCDDEEFF, 1'b0);
        #2;
        n_rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || invShiftRowData !== 128'h0) begin
            errors++;
            $display("FAIL async_reset: got v=%b d=%h expected v=0 d=0", out_valid, invShiftRowData);
        end
        exp_q.delete();
        exp_data = 128'h0;
        in_valid = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        cycle(1'b0, 128'h0, 1'b1);
    endtask

`ifdef INV_SHIFT_ROWS_FWD_SEL_EN
    task automatic test_fwd_sel();
        cycle(1'b1, 128'hDB1C0A0C2B5C453D51D67707F4AC04AA, 1'b1, 1'b1);
        cycle(1'b0, 128'h0, 1'b1);
        checks++;
        if (s_valid !== 1'b1 || s_data !== 128'hDB5C77AA2BD6040C51AC0A3DF41C4507) begin
            errors++;
            $display("FAIL fwd_sel: got v=%b d=%h expected v=1 d=DB5C77AA2BD6040C51AC0A3DF41C4507", s_valid, s_data);
        end
        for (int i = 0; i < 100; i++) begin
            cycle(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        end
        cycle(1'b0, 128'h0, 1'b1);
    endtask
`endif

    initial begin
        test_reset();
        test_vector1();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_async_reset();
`ifdef INV_SHIFT_ROWS_FWD_SEL_EN
        test_fwd_sel();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
